hit_scan_ctrl: RTL
==================

# hit_scan_ctrl

Sequencer that time-shares one hitbox comparator across the five shootable targets: slots 0–3 are the minor enemies and slot 4 is the boss. On each scan tick it snapshots the player bullet and all target positions, then walks the targets one per cycle from a rotating priority pointer. It reports at most one hit per scan: a one-cycle damage pulse with the target id, plus a bullet-kill pulse. It sits between the bullet mover and the enemy/boss HP logic, replacing per-target parallel comparators.

## Interface
- `HIT_W`, default 16: horizontal half-width of the hitbox, in pixels; a hit requires strict `<`.
- `HIT_H`, default 16: vertical half-height of the hitbox, in pixels; a hit requires strict `<`.
- `NT`, default 5: number of target slots. Fixed at 5; the pointer wrap logic assumes it.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: start-scan request, one cycle wide, already synchronous to `clk`.
- `bullet_act` in 1: player bullet is live.
- `bullet_x`, `bullet_y` in 10 each: bullet centre position.
- `tgt_act` in 5: bit i means target i is alive.
- `tgt_x`, `tgt_y` in 50 each: packed target centres; target i occupies bits [10i+9:10i].
- `busy` out 1: a scan is in progress.
- `done` out 1: one-cycle pulse marking the end of a scan.
- `hit` out 1: one-cycle pulse, coincident with `done`, when the scan found a hit.
- `hit_id` out 3: index of the target hit; meaningful only while `hit` is high.
- `bullet_kill` out 1: equal to `hit`; tells the bullet mover to retire the bullet.
- `ovr` out 1: sticky flag, set when a `tick` is dropped; cleared only by `rst`.
- `hit_cnt` out 16: saturating count of all hits.

## Operation
- States: `IDLE`, `SCAN`, `DONE`.
- `IDLE`, `tick` high, `bullet_act` high:
  - latch `bullet_x`/`bullet_y`, `tgt_act`, `tgt_x`/`tgt_y` into snapshot registers;
  - load `idx` from `ptr`; clear `step`;
  - go to `SCAN`.
- `IDLE`, `tick` high, `bullet_act` low: go straight to `DONE` with no hit.
- `SCAN`, each cycle:
  - compare the snapshot bullet against snapshot target `idx`;
  - `dx` = |{1'b0,bx} − {1'b0,tx}|, computed at 11 bits and made non-negative; `dy` is formed the same way;
  - match = `tgt_act[idx]` & (`dx` < `HIT_W`) & (`dy` < `HIT_H`).
- On a match:
  - register `hit_id` = `idx`;
  - set `ptr` = (`idx`+1) mod 5;
  - go to `DONE` with the hit flag set.
- No match:
  - `idx` = (`idx`+1) mod 5; `step` +1;
  - when `step` == 4 (all five checked), go to `DONE` with no hit.
- Inactive targets still take their cycle, so scan length does not depend on `tgt_act`.
- `DONE`:
  - `done` = 1; `hit` = `bullet_kill` = the hit flag;
  - `hit_cnt` increments on a hit and saturates at 16'hFFFF;
  - return to `IDLE`.
- `ptr` moves only on a hit. A miss leaves it unchanged.
- `tick` in `SCAN` or `DONE` is dropped and sets `ovr`. The scan in progress is not disturbed.
- Input changes during a scan have no effect; only snapshot values are used.

## Timing
- Reset values:
  - state `IDLE`; `ptr`, `idx`, `step` = 0;
  - `busy`, `done`, `hit`, `bullet_kill`, `ovr` = 0; `hit_id` = 0; `hit_cnt` = 0.
- All outputs are registered; `busy` is high in `SCAN` and `DONE`.
- Cycle numbering below takes the `tick` cycle as c0.
- Hit on the k-th compared target (k = 1..5): `SCAN` runs c1..ck; `done`/`hit` are high in c(k+1); back in `IDLE` at c(k+2).
- No hit: `SCAN` runs c1..c5; `done` is high in c6 with `hit` = 0.
- Bullet inactive: `done` in c1, `hit` = 0; `busy` is high only in c1.
- A `tick` in c(k+2) or later is accepted. Back-to-back scans are therefore spaced at least k+2 cycles.
- `rst` mid-scan: the next cycle is `IDLE` with all outputs at their reset values. No `done` is emitted for the aborted scan.

## Test plan
- Reset, then `tick` with bullet (100,100) and only target 2 active at (110,95): response is `SCAN` c1..c3, then in c4 `done` = `hit` = `bullet_kill` = 1, `hit_id` = 2, `hit_cnt` = 1, `ptr` = 3.
- Bullet overlaps targets 0 and 4, `ptr` = 0: first scan gives `hit_id` = 0. Repeat with identical positions: second scan starts at 1 and gives `hit_id` = 4, then `ptr` = 0.
- Bullet (200,200), target 1 at (216,200), `dx` = 16: no hit, and `done` arrives in c6. Move the target to (215,200): hit.
- `bullet_act` = 0 with `tick`: `done` in c1, `hit` = 0, `hit_cnt` unchanged.
- `tick` again in c2 of a scan: it is dropped, `ovr` = 1, and the original scan still completes. Assert `rst` in c3 of a new scan: next cycle `busy` = 0, no `done`, `ovr` = 0.
- Force `hit_cnt` to 16'hFFFE, then make two hits: `hit_cnt` reads FFFF and stays there.

Source files
------------

// File: rtl/hit_scan_ctrl.sv
// Time-shared hitbox comparator: one scan per tick walks the five targets from a
// rotating priority pointer and reports at most one hit, with damage and bullet-kill pulses.
module hit_scan_ctrl #(
  parameter int HIT_W = 16,
  parameter int HIT_H = 16,
  parameter int NT    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             bullet_act,
  input  logic [9:0]       bullet_x,
  input  logic [9:0]       bullet_y,
  input  logic [NT-1:0]    tgt_act,
  input  logic [10*NT-1:0] tgt_x,
  input  logic [10*NT-1:0] tgt_y,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [2:0]       hit_id,
  output logic             bullet_kill,
  output logic             ovr,
  output logic [15:0]      hit_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [10:0] HIT_W_L = 11'(HIT_W);
  localparam logic [10:0] HIT_H_L = 11'(HIT_H);
  localparam logic [2:0]  LAST_IDX = 3'(NT - 1);

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      step_q, step_d;
  logic            hit_flag_q, hit_flag_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            hit_q, hit_d;
  logic [2:0]      hit_id_q, hit_id_d;
  logic            ovr_q, ovr_d;
  logic [15:0]     hit_cnt_q, hit_cnt_d;
  logic            snap_load;

  logic [9:0]      bx_q, by_q;
  logic [NT-1:0]   act_q;
  logic [9:0]      tx_q [NT];
  logic [9:0]      ty_q [NT];
  logic [9:0]      tgt_x_arr [NT];
  logic [9:0]      tgt_y_arr [NT];

  generate
    for (genvar gi = 0; gi < NT; gi++) begin : g_unpack
      assign tgt_x_arr[gi] = tgt_x[10*gi +: 10];
      assign tgt_y_arr[gi] = tgt_y[10*gi +: 10];
    end
  endgenerate

  logic [10:0] diff_x, diff_y, dx, dy;
  logic [2:0]  idx_inc;
  logic        match;

  always_comb begin
    diff_x  = {1'b0, bx_q} - {1'b0, tx_q[idx_q]};
    diff_y  = {1'b0, by_q} - {1'b0, ty_q[idx_q]};
    // 11-bit difference is two's complement; fold negatives to magnitude
    dx      = diff_x[10] ? (11'd0 - diff_x) : diff_x;
    dy      = diff_y[10] ? (11'd0 - diff_y) : diff_y;
    match   = act_q[idx_q] & (dx < HIT_W_L) & (dy < HIT_H_L);
    idx_inc = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    step_d     = step_q;
    hit_flag_d = hit_flag_q;
    hit_id_d   = hit_id_q;
    hit_cnt_d  = hit_cnt_q;
    snap_load  = 1'b0;
    ovr_d      = ovr_q | (tick & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (tick) begin
          hit_flag_d = 1'b0;
          if (bullet_act) begin
            snap_load = 1'b1;
            idx_d     = ptr_q;
            step_d    = 3'd0;
            state_d   = SCAN;
          end else begin
            state_d = DONE;
          end
        end
      end
      SCAN: begin
        if (match) begin
          hit_id_d   = idx_q;
          ptr_d      = idx_inc;
          hit_flag_d = 1'b1;
          state_d    = DONE;
          if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
        end else begin
          idx_d  = idx_inc;
          step_d = step_q + 3'd1;
          if (step_q == 3'd4) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // outputs are registered, so derive them from the next state
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    hit_d  = (state_d == DONE) & hit_flag_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd0;
      idx_q      <= 3'd0;
      step_q     <= 3'd0;
      hit_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      hit_id_q   <= 3'd0;
      ovr_q      <= 1'b0;
      hit_cnt_q  <= 16'd0;
      bx_q       <= 10'd0;
      by_q       <= 10'd0;
      act_q      <= '0;
      for (int i = 0; i < NT; i++) begin
        tx_q[i] <= 10'd0;
        ty_q[i] <= 10'd0;
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      step_q     <= step_d;
      hit_flag_q <= hit_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      hit_id_q   <= hit_id_d;
      ovr_q      <= ovr_d;
      hit_cnt_q  <= hit_cnt_d;
      if (snap_load) begin
        bx_q  <= bullet_x;
        by_q  <= bullet_y;
        act_q <= tgt_act;
        for (int i = 0; i < NT; i++) begin
          tx_q[i] <= tgt_x_arr[i];
          ty_q[i] <= tgt_y_arr[i];
        end
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hit         = hit_q;
  assign bullet_kill = hit_q;
  assign hit_id      = hit_id_q;
  assign ovr         = ovr_q;
  assign hit_cnt     = hit_cnt_q;

endmodule
